// File: rtl/toy_bpu_predecode_filter.sv
// Fetch-block predecode filter: splits halfwords into RVC/32-bit instruction channels and
// stitches a 32-bit instruction that straddles two blocks. RAS hints: TOY_BPU_FILTER_RAS_HINT_EN.

module toy_bpu_predecode_filter #(
  parameter int unsigned NUM_HW     = 8,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           blk_vld,
  output logic                           blk_rdy,
  input  logic [ADDR_WIDTH-1:0]          blk_pc,
  input  logic [16*NUM_HW-1:0]           blk_data,
  input  logic [$clog2(NUM_HW)-1:0]      blk_last,
  input  logic                           blk_taken,
  input  logic [ADDR_WIDTH-1:0]          blk_tgt_pc,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic [NUM_HW-1:0]              out_en,
  output logic [32*NUM_HW-1:0]           out_inst,
  output logic [ADDR_WIDTH*NUM_HW-1:0]   out_pc,
  output logic [NUM_HW-1:0]              out_rvc,
  output logic [ADDR_WIDTH-1:0]          out_nxt_pc,
  output logic                           out_is_call,
  output logic                           out_is_ret,
  output logic                           carry_drop
);

  localparam int unsigned LW = $clog2(NUM_HW);
  localparam int unsigned CW = LW + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CARRY = 1'b1;

  logic [0:0]                           state_q, state_d;
  logic [15:0]                          carry_hw_q, carry_hw_d;
  logic [ADDR_WIDTH-1:0]                carry_pc_q, carry_pc_d;

  logic [NUM_HW-1:0][15:0]              blk_hw;
  logic [NUM_HW:0][15:0]                hw_ext;
  logic                                 accept;
  logic                                 merge;
  logic                                 drop;
  logic                                 form;
  logic [CW-1:0]                        ch;
  logic                                 skip;
  logic [15:0]                          hw;
  logic [ADDR_WIDTH-1:0]                hw_pc;
  logic [ADDR_WIDTH-1:0]                nxt_pc_d;

  logic [NUM_HW-1:0]                    en_d, rvc_d;
  logic [NUM_HW-1:0][31:0]              inst_d;
  logic [NUM_HW-1:0][ADDR_WIDTH-1:0]    pc_d;
  logic [NUM_HW-1:0][31:0]              inst_q;
  logic [NUM_HW-1:0][ADDR_WIDTH-1:0]    pc_q;

`ifdef TOY_BPU_FILTER_RAS_HINT_EN
  logic [31:0]                          last_inst;
  logic                                 call_d, ret_d;
`endif

  assign blk_hw   = blk_data;
  assign hw_ext   = {16'h0000, blk_data};
  assign blk_rdy  = (~out_vld | out_rdy) & ~flush;
  assign accept   = blk_vld & blk_rdy;
  assign merge    = (state_q == ST_CARRY) && (blk_pc == carry_pc_q + ADDR_WIDTH'(2));
  assign drop     = (state_q == ST_CARRY) && !merge;
  assign nxt_pc_d = blk_taken ? blk_tgt_pc
                              : blk_pc + (ADDR_WIDTH'(blk_last) << 1) + ADDR_WIDTH'(2);
  assign out_inst = inst_q;
  assign out_pc   = pc_q;

  // Halfword walk: channel assignment, carry formation and next carry state
  always_comb begin
    en_d       = '0;
    rvc_d      = '0;
    inst_d     = '0;
    pc_d       = '0;
    ch         = '0;
    skip       = 1'b0;
    form       = 1'b0;
    hw         = '0;
    hw_pc      = '0;
    state_d    = state_q;
    carry_hw_d = carry_hw_q;
    carry_pc_d = carry_pc_q;
`ifdef TOY_BPU_FILTER_RAS_HINT_EN
    last_inst  = '0;
`endif

    if (merge) begin
      en_d[0]   = 1'b1;
      inst_d[0] = {blk_hw[0], carry_hw_q};
      pc_d[0]   = carry_pc_q;
      ch        = CW'(1);
      skip      = 1'b1;
`ifdef TOY_BPU_FILTER_RAS_HINT_EN
      last_inst = {blk_hw[0], carry_hw_q};
`endif
    end

    for (int h = 0; h < NUM_HW; h++) begin
      hw    = hw_ext[h];
      hw_pc = blk_pc + ADDR_WIDTH'(2 * h);
      if (LW'(h) <= blk_last) begin
        if (skip) begin
          skip = 1'b0;
        end else if (hw[1:0] == 2'b11) begin
          // A 32-bit start on the last halfword either waits for the next block or dies
          if (LW'(h) == blk_last) begin
            form = ~blk_taken;
          end else begin
            en_d[ch[LW-1:0]]   = 1'b1;
            inst_d[ch[LW-1:0]] = {hw_ext[h+1], hw};
            pc_d[ch[LW-1:0]]   = hw_pc;
            ch                 = ch + CW'(1);
            skip               = 1'b1;
`ifdef TOY_BPU_FILTER_RAS_HINT_EN
            last_inst          = {hw_ext[h+1], hw};
`endif
          end
        end else begin
          en_d[ch[LW-1:0]]   = 1'b1;
          rvc_d[ch[LW-1:0]]  = 1'b1;
          inst_d[ch[LW-1:0]] = {16'h0000, hw};
          pc_d[ch[LW-1:0]]   = hw_pc;
          ch                 = ch + CW'(1);
`ifdef TOY_BPU_FILTER_RAS_HINT_EN
          last_inst          = {16'h0000, hw};
`endif
        end
      end
    end

    if (flush) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      state_d = form ? ST_CARRY : ST_IDLE;
      if (form) begin
        carry_hw_d = blk_hw[blk_last];
        carry_pc_d = blk_pc + (ADDR_WIDTH'(blk_last) << 1);
      end
    end
  end

`ifdef TOY_BPU_FILTER_RAS_HINT_EN
  logic [4:0] rd, rs1;
  logic       is_jal, is_jalr, is_c_jr, is_c_jalr;

  // Call/return classification of the last emitted instruction
  always_comb begin
    rd        = last_inst[11:7];
    rs1       = last_inst[19:15];
    is_jal    = (last_inst[6:0] == 7'b1101111);
    is_jalr   = (last_inst[6:0] == 7'b1100111) && (last_inst[14:12] == 3'b000);
    is_c_jr   = (last_inst[15:12] == 4'b1000) && (rd != 5'd0) &&
                (last_inst[6:2] == 5'd0) && (last_inst[1:0] == 2'b10);
    is_c_jalr = (last_inst[15:12] == 4'b1001) && (rd != 5'd0) &&
                (last_inst[6:2] == 5'd0) && (last_inst[1:0] == 2'b10);
    call_d    = ((is_jal | is_jalr) && (rd == 5'd1 || rd == 5'd5)) || is_c_jalr;
    ret_d     = (is_jalr && (rs1 == 5'd1 || rs1 == 5'd5) && (rs1 != rd) &&
                 (last_inst[31:20] == 12'd0)) ||
                (is_c_jr && (rd == 5'd1 || rd == 5'd5)) ||
                (is_c_jalr && (rd == 5'd5));
  end
`else
  assign out_is_call = 1'b0;
  assign out_is_ret  = 1'b0;
`endif

  // State, carry and output group registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      carry_hw_q  <= '0;
      carry_pc_q  <= '0;
      out_vld     <= 1'b0;
      out_en      <= '0;
      out_rvc     <= '0;
      inst_q      <= '0;
      pc_q        <= '0;
      out_nxt_pc  <= '0;
      carry_drop  <= 1'b0;
`ifdef TOY_BPU_FILTER_RAS_HINT_EN
      out_is_call <= 1'b0;
      out_is_ret  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      carry_hw_q <= carry_hw_d;
      carry_pc_q <= carry_pc_d;
      if (flush) begin
        out_vld    <= 1'b0;
        carry_drop <= 1'b0;
      end else begin
        carry_drop <= accept & drop;
        if (accept) begin
          out_vld     <= 1'b1;
          out_en      <= en_d;
          out_rvc     <= rvc_d;
          inst_q      <= inst_d;
          pc_q        <= pc_d;
          out_nxt_pc  <= nxt_pc_d;
`ifdef TOY_BPU_FILTER_RAS_HINT_EN
          out_is_call <= call_d;
          out_is_ret  <= ret_d;
`endif
        end else if (out_rdy) begin
          out_vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_toy_bpu_predecode_filter.sv
// Bench for toy_bpu_predecode_filter: directed vector table, corner sequences and
// randomized blocks checked against a queue-based reference model.

module tb_toy_bpu_predecode_filter;

  localparam int NHW = 8;
  localparam int AW  = 32;
`ifdef TOY_BPU_FILTER_RAS_HINT_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, flush, blk_vld, blk_rdy, blk_taken, out_vld, out_rdy;
  logic [AW-1:0]     blk_pc, blk_tgt_pc, out_nxt_pc;
  logic [16*NHW-1:0] blk_data;
  logic [2:0]        blk_last;
  logic [NHW-1:0]    out_en, out_rvc;
  logic [32*NHW-1:0] out_inst;
  logic [AW*NHW-1:0] out_pc;
  logic              out_is_call, out_is_ret, carry_drop;

  always #5 clk = ~clk;

  toy_bpu_predecode_filter #(.NUM_HW(NHW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .blk_vld(blk_vld), .blk_rdy(blk_rdy),
    .blk_pc(blk_pc), .blk_data(blk_data), .blk_last(blk_last), .blk_taken(blk_taken),
    .blk_tgt_pc(blk_tgt_pc), .out_vld(out_vld), .out_rdy(out_rdy), .out_en(out_en),
    .out_inst(out_inst), .out_pc(out_pc), .out_rvc(out_rvc), .out_nxt_pc(out_nxt_pc),
    .out_is_call(out_is_call), .out_is_ret(out_is_ret), .carry_drop(carry_drop)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Block being presented
  logic [15:0]   s_hw [NHW];
  logic [31:0]   b_pc, b_tgt;
  logic [2:0]    b_last;
  logic          b_taken;

  // Reference model state and expected group
  bit            m_vld, m_cv;
  logic [15:0]   m_chw;
  logic [31:0]   m_cpc;
  logic [NHW-1:0] e_en, e_rvc;
  logic [31:0]   e_inst [NHW];
  logic [31:0]   e_pc [NHW];
  logic [31:0]   e_nxt;
  bit            e_call, e_ret, e_drop;
  bit            rdy_seen, acc_seen;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    bit          rvc;
  } ent_t;

  typedef struct packed {
    logic [31:0]  pc;
    logic [127:0] data;
    logic [2:0]   last;
    logic         taken;
    logic [31:0]  tgt;
    logic [7:0]   e_en;
    logic [7:0]   e_rvc;
    logic [31:0]  e_inst0;
    logic [31:0]  e_inst1;
    logic [31:0]  e_pc1;
    logic [31:0]  e_nxt;
    logic         e_call;
    logic         e_ret;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

`ifdef TOY_BPU_FILTER_RAS_HINT_EN
  function automatic bit is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic void ras_decode(input logic [31:0] i, output bit call, output bit ret);
    bit jal, jalr, c_jr, c_jalr;
    jal    = (i[6:0] == 7'h6F);
    jalr   = (i[6:0] == 7'h67) && (i[14:12] == 3'b000);
    c_jr   = (i[31:16] == 16'h0) && (i[15:12] == 4'b1000) && (i[11:7] != 5'd0) && (i[6:0] == 7'b0000010);
    c_jalr = (i[31:16] == 16'h0) && (i[15:12] == 4'b1001) && (i[11:7] != 5'd0) && (i[6:0] == 7'b0000010);
    call   = ((jal || jalr) && is_link(i[11:7])) || c_jalr;
    ret    = (jalr && is_link(i[19:15]) && (i[19:15] != i[11:7]) && (i[31:20] == 12'h0)) ||
             (c_jr && is_link(i[11:7])) || (c_jalr && (i[11:7] == 5'd5));
  endfunction
`endif

  // Decode the presented block into a list of instructions following the halfword rules
  task automatic model_accept();
    ent_t q[$];
    int h;
    logic [15:0] w;
    e_drop = 1'b0;
    h = 0;
    if (m_cv) begin
      if (b_pc == m_cpc + 32'd2) begin
        q.push_back('{{s_hw[0], m_chw}, m_cpc, 1'b0});
        h = 1;
      end else begin
        e_drop = 1'b1;
      end
    end
    m_cv = 1'b0;
    while (h <= int'(b_last)) begin
      w = s_hw[h];
      if (w[1:0] != 2'b11) begin
        q.push_back('{{16'h0, w}, b_pc + 32'(2 * h), 1'b1});
        h++;
      end else if (h == int'(b_last)) begin
        if (!b_taken) begin
          m_cv  = 1'b1;
          m_chw = w;
          m_cpc = b_pc + 32'(2 * h);
        end
        h++;
      end else begin
        q.push_back('{{s_hw[h+1], w}, b_pc + 32'(2 * h), 1'b0});
        h += 2;
      end
    end
    e_en  = '0;
    e_rvc = '0;
    foreach (q[k]) begin
      e_en[k]   = 1'b1;
      e_rvc[k]  = q[k].rvc;
      e_inst[k] = q[k].inst;
      e_pc[k]   = q[k].pc;
    end
    e_nxt  = b_taken ? b_tgt : b_pc + 32'(2 * (int'(b_last) + 1));
    e_call = 1'b0;
    e_ret  = 1'b0;
`ifdef TOY_BPU_FILTER_RAS_HINT_EN
    if (q.size() > 0) ras_decode(q[q.size()-1].inst, e_call, e_ret);
`endif
  endtask

  task automatic check_outputs();
    chk("out_vld", 64'(out_vld), 64'(m_vld));
    chk("carry_drop", 64'(carry_drop), 64'(e_drop));
    if (m_vld) begin
      chk("out_en", 64'(out_en), 64'(e_en));
      chk("out_nxt_pc", 64'(out_nxt_pc), 64'(e_nxt));
      chk("out_is_call", 64'(out_is_call), 64'(e_call));
      chk("out_is_ret", 64'(out_is_ret), 64'(e_ret));
      for (int k = 0; k < NHW; k++) begin
        if (e_en[k]) begin
          chk($sformatf("inst[%0d]", k), 64'(out_inst[32*k +: 32]), 64'(e_inst[k]));
          chk($sformatf("pc[%0d]", k), 64'(out_pc[AW*k +: AW]), 64'(e_pc[k]));
          chk($sformatf("rvc[%0d]", k), 64'(out_rvc[k]), 64'(e_rvc[k]));
        end
      end
    end
  endtask

  // One clock: drive at negedge, check blk_rdy, advance model, check registered outputs
  task automatic cycle(input bit f, input bit v, input bit r);
    bit e_rdy;
    @(negedge clk);
    flush      = f;
    blk_vld    = v;
    out_rdy    = r;
    blk_pc     = b_pc;
    blk_last   = b_last;
    blk_taken  = b_taken;
    blk_tgt_pc = b_tgt;
    for (int i = 0; i < NHW; i++) blk_data[16*i +: 16] = s_hw[i];
    #1;
    rdy_seen = blk_rdy;
    e_rdy    = (!m_vld || r) && !f;
    acc_seen = 1'b0;
    if (rst_n) chk("blk_rdy", 64'(blk_rdy), 64'(e_rdy));
    if (!rst_n || f) begin
      m_vld  = 1'b0;
      m_cv   = 1'b0;
      e_drop = 1'b0;
    end else if (v && e_rdy) begin
      model_accept();
      m_vld    = 1'b1;
      acc_seen = 1'b1;
    end else begin
      e_drop = 1'b0;
      if (r) m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_blk(input logic [31:0] pc, input logic [127:0] data, input logic [2:0] last,
                         input logic taken, input logic [31:0] tgt);
    b_pc = pc; b_last = last; b_taken = taken; b_tgt = tgt;
    for (int i = 0; i < NHW; i++) s_hw[i] = data[16*i +: 16];
  endtask

  // Seven RVC halfwords then a 32-bit start on the last halfword at 0x100E
  task automatic blk_with_carry();
    set_blk(32'h1000, {16'h0003, {7{16'h0001}}}, 3'd7, 1'b0, 32'h0);
  endtask

  logic [31:0] seq_pc;

  initial begin
    rst_n = 1'b0; flush = 1'b0; blk_vld = 1'b0; out_rdy = 1'b1;
    blk_pc = '0; blk_data = '0; blk_last = '0; blk_taken = 1'b0; blk_tgt_pc = '0;
    m_vld = 1'b0; m_cv = 1'b0; m_chw = '0; m_cpc = '0; e_drop = 1'b0;
    e_en = '0; e_rvc = '0; e_nxt = '0; e_call = 1'b0; e_ret = 1'b0;
    set_blk(32'h0, 128'h0, 3'd0, 1'b0, 32'h0);

    vt[0] = '{32'h1000, {16'h411C, 16'h4118, 16'h4114, 16'h4110, 16'h410C, 16'h4108, 16'h4104, 16'h4100},
              3'd7, 1'b0, 32'h0, 8'hFF, 8'hFF, 32'h4100, 32'h4104, 32'h1002, 32'h1010, 1'b0, 1'b0};
    vt[1] = '{32'h1000, {16'h0040, 16'h0693, 16'h0030, 16'h0613, 16'h0020, 16'h0593, 16'h0010, 16'h0513},
              3'd7, 1'b0, 32'h0, 8'h0F, 8'h00, 32'h00100513, 32'h00200593, 32'h1004, 32'h1010, 1'b0, 1'b0};
    vt[2] = '{32'h1200, {112'h0, 16'h0003}, 3'd0, 1'b1, 32'h8000,
              8'h00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h8000, 1'b0, 1'b0};
    vt[3] = '{32'h2000, {64'h0, 16'h8082, 16'h0010, 16'h0513, 16'h4501}, 3'd3, 1'b1, 32'h3000,
              8'h07, 8'h05, 32'h4501, 32'h00100513, 32'h2002, 32'h3000, 1'b0, 1'b1};
    vt[4] = '{32'h3000, {96'h0, 16'h0000, 16'h80E7}, 3'd1, 1'b0, 32'h0,
              8'h01, 8'h00, 32'h000080E7, 32'h0, 32'h0, 32'h3004, 1'b1, 1'b0};
    vt[5] = '{32'hFFFFFFFC, {80'h0, 16'h0001, 16'h0001, 16'h0001}, 3'd2, 1'b0, 32'h0,
              8'h07, 8'h07, 32'h1, 32'h1, 32'hFFFFFFFE, 32'h00000002, 1'b0, 1'b0};
    vt[6] = '{32'h4000, {80'h0, 16'h0003, 16'h0000, 16'h00EF}, 3'd2, 1'b0, 32'h0,
              8'h01, 8'h00, 32'h000000EF, 32'h0, 32'h0, 32'h4006, 1'b1, 1'b0};
    vt[7] = '{32'h5000, {96'h0, 16'h9282, 16'h0001}, 3'd1, 1'b0, 32'h0,
              8'h03, 8'h03, 32'h1, 32'h9282, 32'h5002, 32'h5004, 1'b1, 1'b1};

    // Reset
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    #1;
    chk("reset out_vld", 64'(out_vld), 64'h0);
    chk("reset out_en", 64'(out_en), 64'h0);
    chk("reset carry_drop", 64'(carry_drop), 64'h0);
    chk("reset blk_rdy", 64'(blk_rdy), 64'h1);

    // Directed vector table, each from a clean state
    for (int t = 0; t < 8; t++) begin
      set_blk(vt[t].pc, vt[t].data, vt[t].last, vt[t].taken, vt[t].tgt);
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);
      chk($sformatf("tv%0d en", t), 64'(out_en), 64'(vt[t].e_en));
      chk($sformatf("tv%0d rvc", t), 64'(out_rvc & vt[t].e_en), 64'(vt[t].e_rvc));
      chk($sformatf("tv%0d nxt", t), 64'(out_nxt_pc), 64'(vt[t].e_nxt));
      chk($sformatf("tv%0d call", t), 64'(out_is_call), 64'(RAS_EN & vt[t].e_call));
      chk($sformatf("tv%0d ret", t), 64'(out_is_ret), 64'(RAS_EN & vt[t].e_ret));
      if (vt[t].e_en[0]) begin
        chk($sformatf("tv%0d inst0", t), 64'(out_inst[31:0]), 64'(vt[t].e_inst0));
        chk($sformatf("tv%0d pc0", t), 64'(out_pc[AW-1:0]), 64'(vt[t].pc));
      end
      if (vt[t].e_en[1]) begin
        chk($sformatf("tv%0d inst1", t), 64'(out_inst[63:32]), 64'(vt[t].e_inst1));
        chk($sformatf("tv%0d pc1", t), 64'(out_pc[2*AW-1:AW]), 64'(vt[t].e_pc1));
      end
    end

    // Carry stitched across contiguous blocks
    cycle(1'b1, 1'b0, 1'b1);
    blk_with_carry();
    cycle(1'b0, 1'b1, 1'b1);
    chk("carry blk1 en", 64'(out_en), 64'h7F);
    set_blk(32'h1010, {{7{16'h0001}}, 16'h1234}, 3'd7, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1);
    chk("merge inst0", 64'(out_inst[31:0]), 64'h12340003);
    chk("merge pc0", 64'(out_pc[AW-1:0]), 64'h100E);
    chk("merge rvc0", 64'(out_rvc[0]), 64'h0);
    chk("merge en", 64'(out_en), 64'hFF);
    chk("merge drop", 64'(carry_drop), 64'h0);

    // Carry dropped by a non-contiguous block
    cycle(1'b1, 1'b0, 1'b1);
    blk_with_carry();
    cycle(1'b0, 1'b1, 1'b1);
    set_blk(32'h2000, {8{16'h0001}}, 3'd7, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1);
    chk("drop pulse", 64'(carry_drop), 64'h1);
    chk("drop pc0", 64'(out_pc[AW-1:0]), 64'h2000);
    cycle(1'b0, 1'b0, 1'b1);
    chk("drop pulse end", 64'(carry_drop), 64'h0);

    // Backpressure holds the group and blocks acceptance
    cycle(1'b1, 1'b0, 1'b1);
    set_blk(vt[0].pc, vt[0].data, vt[0].last, vt[0].taken, vt[0].tgt);
    cycle(1'b0, 1'b1, 1'b1);
    set_blk(32'h6000, {8{16'h0005}}, 3'd7, 1'b0, 32'h0);
    for (int s = 0; s < 3; s++) begin
      cycle(1'b0, 1'b1, 1'b0);
      chk($sformatf("stall%0d blk_rdy", s), 64'(rdy_seen), 64'h0);
      chk($sformatf("stall%0d pc0", s), 64'(out_pc[AW-1:0]), 64'h1000);
      chk($sformatf("stall%0d inst7", s), 64'(out_inst[255:224]), 64'h411C);
    end
    cycle(1'b0, 1'b1, 1'b1);
    chk("release blk_rdy", 64'(rdy_seen), 64'h1);
    chk("release pc0", 64'(out_pc[AW-1:0]), 64'h6000);

    // Flush with carry held and group valid
    cycle(1'b1, 1'b0, 1'b1);
    blk_with_carry();
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    chk("flush blk_rdy", 64'(rdy_seen), 64'h0);
    chk("flush out_vld", 64'(out_vld), 64'h0);
    set_blk(32'h1010, {{7{16'h0001}}, 16'h1234}, 3'd7, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1);
    chk("post-flush inst0", 64'(out_inst[31:0]), 64'h1234);
    chk("post-flush pc0", 64'(out_pc[AW-1:0]), 64'h1010);
    chk("post-flush drop", 64'(carry_drop), 64'h0);

    // Reset mid-operation discards group and carry
    blk_with_carry();
    cycle(1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, 1'b1);
    chk("mid-reset out_vld", 64'(out_vld), 64'h0);
    rst_n = 1'b1;
    set_blk(32'h1010, {{7{16'h0001}}, 16'h1234}, 3'd7, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1);
    chk("post-reset inst0", 64'(out_inst[31:0]), 64'h1234);
    chk("post-reset drop", 64'(carry_drop), 64'h0);

    // Randomized traffic against the reference model
    seq_pc = 32'h8000;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NHW; i++) begin
        s_hw[i] = 16'($urandom);
        if ($urandom_range(1, 0) == 1) s_hw[i][1:0] = 2'b11;
      end
      b_last  = 3'($urandom_range(7, 0));
      b_taken = ($urandom_range(3, 0) == 0);
      b_tgt   = $urandom & 32'hFFFF_FFFE;
      if ($urandom_range(3, 0) != 0)       b_pc = seq_pc;
      else if ($urandom_range(3, 0) == 0)  b_pc = 32'hFFFF_FFF0 | ($urandom & 32'hE);
      else                                 b_pc = $urandom & 32'hFFFF_FFFE;
      cycle($urandom_range(31, 0) == 0, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
      if (acc_seen) seq_pc = b_pc + 32'(2 * (int'(b_last) + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
